// File: rtl/reorder_buffer_pkg.sv
// Shared sizing constants and entry/lane record types for the reorder buffer.
package reorder_buffer_pkg;
  localparam int ROB_DEPTH      = 16;
  localparam int ROB_DISPATCH_W = 2;
  localparam int ROB_COMPLETE_W = 3;
  localparam int ROB_RETIRE_W   = 2;
  localparam int ROB_DATA_W     = 32;
  localparam int ROB_PREG_W     = 6;
  localparam int ROB_IDX_W      = $clog2(ROB_DEPTH);
  localparam int ROB_RCNT_W     = $clog2(ROB_RETIRE_W + 1);

  typedef struct packed {
    logic                  valid;
    logic                  complete;
    logic [ROB_PREG_W-1:0] pdst;
    logic [ROB_PREG_W-1:0] old_pdst;
    logic [ROB_DATA_W-1:0] data;
    logic                  regwrite;
    logic                  memwrite;
  } rob_entry_t;

  typedef struct packed {
    logic [ROB_PREG_W-1:0] pdst;
    logic [ROB_PREG_W-1:0] old_pdst;
    logic                  regwrite;
    logic                  memwrite;
  } rob_alloc_t;

  typedef struct packed {
    logic                  valid;
    logic [ROB_IDX_W-1:0]  rob_num;
    logic [ROB_DATA_W-1:0] data;
  } rob_cmpl_t;

  typedef struct packed {
    logic                  valid;
    logic [ROB_IDX_W-1:0]  rob_num;
    logic [ROB_PREG_W-1:0] pdst;
    logic [ROB_PREG_W-1:0] old_pdst;
    logic [ROB_DATA_W-1:0] data;
    logic                  regwrite;
    logic                  memwrite;
  } rob_retire_t;
endpackage

// File: rtl/rob_retire_select.sv
// Picks the in-order retire group: the leading run of ready entries from head, capped at RETIRE_W.
module rob_retire_select #(
  parameter int RETIRE_W = 2,
  parameter int IDX_W    = 4,
  parameter int CNT_W    = 2
) (
  input  logic [RETIRE_W-1:0]            rdy,
  input  logic [IDX_W-1:0]               head,
  output logic [CNT_W-1:0]               n,
  output logic [RETIRE_W-1:0]            take,
  output logic [RETIRE_W-1:0][IDX_W-1:0] idx
);
  logic run;

  always_comb begin
    n    = '0;
    take = '0;
    idx  = '0;
    run  = 1'b1;
    for (int j = 0; j < RETIRE_W; j++) begin
      // first not-ready slot ends the group; later ready slots stay put
      run     = run & rdy[j];
      take[j] = run;
      n       = n + CNT_W'(run);
      idx[j]  = head + IDX_W'(j);
    end
  end
endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates ROB numbers at tail, absorbs writebacks, retires in order from head.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH      = ROB_DEPTH,
  parameter int DISPATCH_W = ROB_DISPATCH_W,
  parameter int COMPLETE_W = ROB_COMPLETE_W,
  parameter int RETIRE_W   = ROB_RETIRE_W,
  parameter int DATA_W     = ROB_DATA_W,
  parameter int PREG_W     = ROB_PREG_W,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_flush,
  input  logic [DISPATCH_W-1:0]               i_alloc_valid,
  input  logic [DISPATCH_W-1:0][PREG_W-1:0]   i_alloc_pdst,
  input  logic [DISPATCH_W-1:0][PREG_W-1:0]   i_alloc_old_pdst,
  input  logic [DISPATCH_W-1:0]               i_alloc_regwrite,
  input  logic [DISPATCH_W-1:0]               i_alloc_memwrite,
  output logic                                o_alloc_ready,
  output logic [DISPATCH_W-1:0][IDX_W-1:0]    o_alloc_rob_num,
  input  logic [COMPLETE_W-1:0]               i_cmpl_valid,
  input  logic [COMPLETE_W-1:0][IDX_W-1:0]    i_cmpl_rob_num,
  input  logic [COMPLETE_W-1:0][DATA_W-1:0]   i_cmpl_data,
  output logic [RETIRE_W-1:0]                 o_retire_valid,
  output logic [RETIRE_W-1:0][IDX_W-1:0]      o_retire_rob_num,
  output logic [RETIRE_W-1:0][PREG_W-1:0]     o_retire_pdst,
  output logic [RETIRE_W-1:0][PREG_W-1:0]     o_retire_old_pdst,
  output logic [RETIRE_W-1:0][DATA_W-1:0]     o_retire_data,
  output logic [RETIRE_W-1:0]                 o_retire_regwrite,
  output logic [RETIRE_W-1:0]                 o_retire_memwrite,
  output logic [IDX_W:0]                      o_count,
  output logic                                o_empty,
  output logic                                o_full
);
  localparam int CNT_W  = IDX_W + 1;
  localparam int RCNT_W = $clog2(RETIRE_W + 1);

  rob_entry_t                  ent [DEPTH];
  rob_retire_t                 ret_q [RETIRE_W];
  logic [IDX_W-1:0]            head, tail;
  logic [CNT_W-1:0]            count, alloc_n;
  logic [RETIRE_W-1:0]         rdy_win, ret_take;
  logic [RETIRE_W-1:0][IDX_W-1:0] ret_idx;
  logic [RCNT_W-1:0]           ret_n;
  logic [IDX_W-1:0]            acc;

  // Ready decision uses the registered count: same-cycle retires do not free slots for this alloc.
  assign o_alloc_ready = (count <= CNT_W'(DEPTH - DISPATCH_W));
  assign o_count       = count;
  assign o_empty       = (count == '0);
  assign o_full        = (count == CNT_W'(DEPTH));

  always_comb begin
    acc             = '0;
    alloc_n         = '0;
    o_alloc_rob_num = '0;
    for (int k = 0; k < DISPATCH_W; k++) begin
      o_alloc_rob_num[k] = tail + acc;
      acc                = acc + IDX_W'(i_alloc_valid[k]);
      alloc_n            = alloc_n + CNT_W'(i_alloc_valid[k] & o_alloc_ready);
    end
  end

  always_comb begin
    rdy_win = '0;
    for (int j = 0; j < RETIRE_W; j++)
      rdy_win[j] = ent[head + IDX_W'(j)].valid && ent[head + IDX_W'(j)].complete;
  end

  rob_retire_select #(.RETIRE_W(RETIRE_W), .IDX_W(IDX_W), .CNT_W(RCNT_W)) u_sel (
    .rdy  (rdy_win),
    .head (head),
    .n    (ret_n),
    .take (ret_take),
    .idx  (ret_idx)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      for (int j = 0; j < RETIRE_W; j++) ret_q[j] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent[i].valid    <= 1'b0;
        ent[i].complete <= 1'b0;
      end
      for (int j = 0; j < RETIRE_W; j++) ret_q[j] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int k = 0; k < DISPATCH_W; k++)
        if (o_alloc_ready && i_alloc_valid[k])
          ent[o_alloc_rob_num[k]] <= '{valid: 1'b1, complete: 1'b0,
                                       pdst: i_alloc_pdst[k], old_pdst: i_alloc_old_pdst[k],
                                       data: '0, regwrite: i_alloc_regwrite[k],
                                       memwrite: i_alloc_memwrite[k]};
      // Ascending lane order makes the highest lane win on a duplicate index.
      for (int c = 0; c < COMPLETE_W; c++)
        if (i_cmpl_valid[c] && ent[i_cmpl_rob_num[c]].valid && !ent[i_cmpl_rob_num[c]].complete) begin
          ent[i_cmpl_rob_num[c]].complete <= 1'b1;
          ent[i_cmpl_rob_num[c]].data     <= i_cmpl_data[c];
        end
      for (int j = 0; j < RETIRE_W; j++) begin
        if (ret_take[j]) begin
          ret_q[j] <= '{valid: 1'b1, rob_num: ret_idx[j],
                        pdst: ent[ret_idx[j]].pdst, old_pdst: ent[ret_idx[j]].old_pdst,
                        data: ent[ret_idx[j]].data, regwrite: ent[ret_idx[j]].regwrite,
                        memwrite: ent[ret_idx[j]].memwrite};
          ent[ret_idx[j]].valid    <= 1'b0;
          ent[ret_idx[j]].complete <= 1'b0;
        end else begin
          ret_q[j] <= '0;
        end
      end
      head  <= head + IDX_W'(ret_n);
      tail  <= tail + IDX_W'(alloc_n);
      count <= count + alloc_n - CNT_W'(ret_n);
    end
  end

  for (genvar j = 0; j < RETIRE_W; j++) begin : g_ret
    assign o_retire_valid[j]    = ret_q[j].valid;
    assign o_retire_rob_num[j]  = ret_q[j].rob_num;
    assign o_retire_pdst[j]     = ret_q[j].pdst;
    assign o_retire_old_pdst[j] = ret_q[j].old_pdst;
    assign o_retire_data[j]     = ret_q[j].data;
    assign o_retire_regwrite[j] = ret_q[j].regwrite;
    assign o_retire_memwrite[j] = ret_q[j].memwrite;
  end

`ifndef SYNTHESIS
  always @(posedge i_clk) begin
    if (i_rst_n && !i_flush) begin
      for (int c = 0; c < COMPLETE_W; c++) begin
        if (i_cmpl_valid[c])
          assert (ent[i_cmpl_rob_num[c]].valid && !ent[i_cmpl_rob_num[c]].complete);
        for (int d = c + 1; d < COMPLETE_W; d++)
          if (i_cmpl_valid[c] && i_cmpl_valid[d])
            assert (i_cmpl_rob_num[c] != i_cmpl_rob_num[d]);
      end
    end
  end
`endif
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: in-order retire, gaps, full/refusal, wrap, flush and reset.
module tb_reorder_buffer;
  logic            clk, rst_n, flush;
  logic [1:0]      alloc_valid, alloc_regwrite, alloc_memwrite;
  logic [1:0][5:0] alloc_pdst, alloc_old_pdst;
  logic            alloc_ready;
  logic [1:0][3:0] alloc_rob_num;
  logic [2:0]      cmpl_valid;
  logic [2:0][3:0] cmpl_rob_num;
  logic [2:0][31:0] cmpl_data;
  logic [1:0]      ret_valid, ret_regwrite, ret_memwrite;
  logic [1:0][3:0] ret_rob_num;
  logic [1:0][5:0] ret_pdst, ret_old_pdst;
  logic [1:0][31:0] ret_data;
  logic [4:0]      count;
  logic            empty, full;
  int              n_tests, n_fail;

  reorder_buffer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_alloc_valid(alloc_valid), .i_alloc_pdst(alloc_pdst), .i_alloc_old_pdst(alloc_old_pdst),
    .i_alloc_regwrite(alloc_regwrite), .i_alloc_memwrite(alloc_memwrite),
    .o_alloc_ready(alloc_ready), .o_alloc_rob_num(alloc_rob_num),
    .i_cmpl_valid(cmpl_valid), .i_cmpl_rob_num(cmpl_rob_num), .i_cmpl_data(cmpl_data),
    .o_retire_valid(ret_valid), .o_retire_rob_num(ret_rob_num), .o_retire_pdst(ret_pdst),
    .o_retire_old_pdst(ret_old_pdst), .o_retire_data(ret_data),
    .o_retire_regwrite(ret_regwrite), .o_retire_memwrite(ret_memwrite),
    .o_count(count), .o_empty(empty), .o_full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    flush = 1'b0; alloc_valid = '0; alloc_pdst = '0; alloc_old_pdst = '0;
    alloc_regwrite = '0; alloc_memwrite = '0;
    cmpl_valid = '0; cmpl_rob_num = '0; cmpl_data = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cmpl(input int lane, input logic [3:0] rob, input logic [31:0] d);
    cmpl_valid[lane] = 1'b1; cmpl_rob_num[lane] = rob; cmpl_data[lane] = d;
  endtask

  // Asynchronous reset asserted between edges; state must clear without a clock.
  task automatic do_reset(input string tag);
    idle();
    rst_n = 1'b0;
    #2;
    check({tag, "_count"}, 64'(count), 64'd0);
    check({tag, "_empty"}, 64'(empty), 64'd1);
    check({tag, "_full"},  64'(full), 64'd0);
    check({tag, "_ready"}, 64'(alloc_ready), 64'd1);
    check({tag, "_rvalid"}, 64'(ret_valid), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst_n = 1'b1;
    idle();
    #1;
    do_reset("rst0");

    // Two lanes, completed out of order, retire together one edge after the head completes.
    alloc_valid = 2'b11; alloc_pdst[0] = 6'd10; alloc_pdst[1] = 6'd11;
    alloc_old_pdst[0] = 6'd20; alloc_old_pdst[1] = 6'd21;
    alloc_regwrite = 2'b11; alloc_memwrite = 2'b10;
    #1;
    check("pair_rob0", 64'(alloc_rob_num[0]), 64'd0);
    check("pair_rob1", 64'(alloc_rob_num[1]), 64'd1);
    tick(); idle();
    check("pair_count", 64'(count), 64'd2);
    cmpl(0, 4'd1, 32'hAAAA_0001);
    tick(); idle();
    check("pair_noret1", 64'(ret_valid), 64'd0);
    cmpl(2, 4'd0, 32'h5555_0000);
    tick(); idle();
    check("pair_noret0", 64'(ret_valid), 64'd0);
    tick();
    check("pair_rvalid", 64'(ret_valid), 64'h3);
    check("pair_rrob0", 64'(ret_rob_num[0]), 64'd0);
    check("pair_rrob1", 64'(ret_rob_num[1]), 64'd1);
    check("pair_rdata0", 64'(ret_data[0]), 64'h5555_0000);
    check("pair_rdata1", 64'(ret_data[1]), 64'hAAAA_0001);
    check("pair_pdst0", 64'(ret_pdst[0]), 64'd10);
    check("pair_old1", 64'(ret_old_pdst[1]), 64'd21);
    check("pair_rw", 64'(ret_regwrite), 64'h3);
    check("pair_mw", 64'(ret_memwrite), 64'h2);
    check("pair_empty", 64'(empty), 64'd1);
    do_reset("rst_mid");

    // Only lane 1 valid: it packs into the tail slot.
    alloc_valid = 2'b10;
    #1;
    check("lane1_rob", 64'(alloc_rob_num[1]), 64'd0);
    // Gap at head blocks younger completed entries.
    alloc_valid = 2'b11; tick(); idle();
    alloc_valid = 2'b11; #1;
    check("ooo_rob2", 64'(alloc_rob_num[0]), 64'd2);
    tick(); idle();
    cmpl(0, 4'd2, 32'd2); cmpl(1, 4'd3, 32'd3);
    tick(); idle(); tick();
    check("ooo_gap", 64'(ret_valid), 64'd0);
    cmpl(1, 4'd0, 32'd100);
    tick(); idle(); tick();
    check("ooo_r0_valid", 64'(ret_valid), 64'h1);
    check("ooo_r0_rob", 64'(ret_rob_num[0]), 64'd0);
    check("ooo_r0_data", 64'(ret_data[0]), 64'd100);
    check("ooo_r0_count", 64'(count), 64'd3);
    cmpl(2, 4'd1, 32'd1);
    tick(); idle();
    check("ooo_r1_wait", 64'(ret_valid), 64'd0);
    tick();
    check("ooo_r12_valid", 64'(ret_valid), 64'h3);
    check("ooo_r12_rob0", 64'(ret_rob_num[0]), 64'd1);
    check("ooo_r12_rob1", 64'(ret_rob_num[1]), 64'd2);
    tick();
    check("ooo_r3_valid", 64'(ret_valid), 64'h1);
    check("ooo_r3_rob", 64'(ret_rob_num[0]), 64'd3);
    check("ooo_r3_data", 64'(ret_data[0]), 64'd3);
    check("ooo_count", 64'(count), 64'd0);
    do_reset("rst_fill");

    // Fill to DEPTH, then confirm requests are dropped.
    for (int i = 0; i < 8; i++) begin
      alloc_valid = 2'b11; alloc_pdst[0] = 6'(2*i); alloc_pdst[1] = 6'(2*i+1);
      tick(); idle();
    end
    check("fill_count", 64'(count), 64'd16);
    check("fill_full", 64'(full), 64'd1);
    check("fill_ready", 64'(alloc_ready), 64'd0);
    alloc_valid = 2'b11; tick(); idle();
    check("fill_drop", 64'(count), 64'd16);
    cmpl(0, 4'd0, 32'hF00D);
    tick(); idle(); tick();
    check("fill_ret", 64'(ret_valid), 64'h1);
    check("fill_ret_pdst", 64'(ret_pdst[0]), 64'd0);
    check("fill_15", 64'(count), 64'd15);
    check("fill_15_ready", 64'(alloc_ready), 64'd0);
    alloc_valid = 2'b01; tick(); idle();
    check("fill_one_refused", 64'(count), 64'd15);
    check("fill_notfull", 64'(full), 64'd0);
    do_reset("rst_wrap");

    // Serial alloc/complete/retire pairs: ROB numbers wrap 15 -> 0.
    for (int i = 0; i < 40; i++) begin
      alloc_valid = 2'b01; alloc_pdst[0] = 6'(i); alloc_old_pdst[0] = 6'(63 - i);
      alloc_regwrite = 2'b01;
      #1;
      check("wrap_anum", 64'(alloc_rob_num[0]), 64'(i % 16));
      tick(); idle();
      check("wrap_cnt1", 64'(count), 64'd1);
      cmpl(i % 3, 4'(i % 16), 32'(i * 7 + 1));
      tick(); idle(); tick();
      check("wrap_rvalid", 64'(ret_valid), 64'h1);
      check("wrap_rrob", 64'(ret_rob_num[0]), 64'(i % 16));
      check("wrap_rdata", 64'(ret_data[0]), 64'(i * 7 + 1));
      check("wrap_rpdst", 64'(ret_pdst[0]), 64'(i));
      check("wrap_cnt0", 64'(count), 64'd0);
    end
    do_reset("rst_flush");

    // Flush beats same-cycle alloc and complete; allocation restarts at ROB#0.
    alloc_valid = 2'b11; tick(); idle();
    alloc_valid = 2'b11; tick(); idle();
    alloc_valid = 2'b01; tick(); idle();
    check("fl_count5", 64'(count), 64'd5);
    cmpl(0, 4'd1, 32'd11); cmpl(1, 4'd3, 32'd33);
    tick(); idle();
    check("fl_gap", 64'(ret_valid), 64'd0);
    flush = 1'b1; alloc_valid = 2'b11; cmpl(0, 4'd0, 32'd10);
    tick(); idle();
    check("fl_count0", 64'(count), 64'd0);
    check("fl_empty", 64'(empty), 64'd1);
    check("fl_rvalid", 64'(ret_valid), 64'd0);
    tick();
    check("fl_rvalid2", 64'(ret_valid), 64'd0);
    alloc_valid = 2'b11; #1;
    check("fl_rob0", 64'(alloc_rob_num[0]), 64'd0);
    check("fl_rob1", 64'(alloc_rob_num[1]), 64'd1);
    tick(); idle();
    check("fl_count2", 64'(count), 64'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
